prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Writer side of the processor's program memory. Receives a byte stream over a valid/ready
//  handshake and assembles big-endian RAM_WIDTH words. Writes them into the prog_mem bram
//  write port and holds the processor in reset until the image is loaded and its checksum is verified.
//  Stream format: 2-byte word count N (MSB first), N*RAM_WIDTH/8 data bytes, 1 XOR checksum byte.
// PARAMETERS
//  RAM_WIDTH        32  memory word width; must be a multiple of 8 (BPW = RAM_WIDTH/8 bytes/word)
//  RAM_ADDR_BITS    9   program memory address width (depth 2**RAM_ADDR_BITS)
//  PROG_START_ADDR  0   address of first loaded word
// PORTS
//  clk              in   1              single clock, all logic on posedge
//  reset            in   1              synchronous, active-high
//  start            in   1              1-cycle pulse: begin a load
//  in_valid         in   1              byte available on in_data
//  in_data          in   8              stream byte
//  in_ready         out  1              loader accepts byte this cycle (transfer = in_valid & in_ready)
//  mem_write_enable out  1              bram write strobe, one cycle per word
//  mem_address      out  RAM_ADDR_BITS  bram write address
//  mem_input_data   out  RAM_WIDTH      bram write data
//  cpu_reset        out  1              hold processor in reset while high
//  done             out  1              load finished, checksum good
//  error            out  1              load aborted: oversize count or checksum mismatch
// BEHAVIOUR
//  Reset: state IDLE; in_ready=0, mem_write_enable=0, mem_address=0, mem_input_data=0,
//   cpu_reset=1, done=0, error=0; word/byte counters and checksum cleared. Reset mid-load aborts; no further writes.
//  States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, CSUM, DONE, ERR.
//  start in IDLE/DONE/ERR -> HDR_HI; clears done, error, checksum, counters; cpu_reset=1.
//   start in any other state is ignored.
//  in_ready=1 only in HDR_HI, HDR_LO, DATA, CSUM; 0 in IDLE, WRITE, DONE, ERR.
//  Checksum: running XOR of every accepted byte, header and data, excluding the checksum byte.
//  HDR_HI: accept byte -> N[15:8]; -> HDR_LO.
//  HDR_LO: accept byte -> N[7:0]. If N > 2**RAM_ADDR_BITS - PROG_START_ADDR -> ERR.
//   Else if N==0 -> CSUM. Else -> DATA.
//  DATA: each accepted byte shifts into the word register at the LSB end (first byte ends in MSB).
//   On the BPW-th byte -> WRITE.
//  WRITE (exactly 1 cycle): mem_write_enable=1, mem_address=PROG_START_ADDR+word_idx,
//   mem_input_data=assembled word. Write occurs the cycle after the last byte of the word.
//   Then word_idx==N-1 -> CSUM, else word_idx++ -> DATA.
//  mem_write_enable=0 in all other states. mem_address/mem_input_data hold their last values.
//  Address never wraps: the oversize check guarantees PROG_START_ADDR+N-1 < 2**RAM_ADDR_BITS.
//  CSUM: accept byte; equal to checksum -> DONE, else -> ERR.
//  DONE: done=1, cpu_reset=0. ERR: error=1, cpu_reset=1. Both states are sticky until start or reset.
//   Words written before an error are not undone.
//  Throughput: 1 byte/cycle while in_valid is held, plus one in_ready=0 bubble per word (WRITE).
//  in_valid low stalls the FSM in its current state with no side effects.
// TESTING
//  1 reset asserted 3 cycles -> all outputs at reset values, cpu_reset=1, in_ready=0.
//  2 start, bytes 00 02 11 22 33 44 AA BB CC DD 46 streamed back-to-back -> writes 0x11223344@0
//    and 0xAABBCCDD@1, each a single-cycle strobe. in_ready low one cycle after bytes 44 and DD.
//    Then done=1, cpu_reset=0.
//  3 as 2 but checksum byte 47 -> both writes occur, error=1, done=0, cpu_reset=1.
//    A new start then repeats test 2 cleanly.
//  4 start, bytes 00 00 00 -> no writes, done=1.
//  5 start, bytes 02 01 (N=513 > 512) -> ERR the cycle after the 2nd byte, no writes, in_ready=0.
//  6 start, header 00 01, bytes 11 22 with in_valid gaps, then reset before the 3rd byte
//    -> no write, state IDLE, cpu_reset=1. Also: start pulsed during DATA is ignored.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: writer side of the processor program memory.
// Receives a byte stream (2-byte word count, data bytes, XOR checksum byte),
// assembles big-endian words, writes them to the bram write port and holds
// the processor in reset until the image is loaded and the checksum matches.
module prog_loader #(
  parameter int RAM_WIDTH       = 32,
  parameter int RAM_ADDR_BITS   = 9,
  parameter int PROG_START_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     mem_write_enable,
  output logic [RAM_ADDR_BITS-1:0] mem_address,
  output logic [RAM_WIDTH-1:0]     mem_input_data,
  output logic                     cpu_reset,
  output logic                     done,
  output logic                     error
);

  localparam int BPW = RAM_WIDTH / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  // Largest word count that still fits between the start address and the top of memory.
  localparam logic [31:0] MAX_WORDS = 32'((1 << RAM_ADDR_BITS) - PROG_START_ADDR);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  state_t                   state;
  logic [7:0]               hdr_hi;
  logic [15:0]              word_count;
  logic [RAM_ADDR_BITS-1:0] word_idx;
  logic [BCW-1:0]           byte_cnt;
  logic [RAM_WIDTH-1:0]     word_reg;
  logic [7:0]               csum;
  logic [RAM_WIDTH-1:0]     next_word;
  logic [15:0]              next_count;

  assign next_word  = (word_reg << 8) | RAM_WIDTH'(in_data);
  assign next_count = {hdr_hi, in_data};

  // Load sequencer: walks the stream format and drives every output from registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      in_ready         <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_input_data   <= '0;
      cpu_reset        <= 1'b1;
      done             <= 1'b0;
      error            <= 1'b0;
      hdr_hi           <= '0;
      word_count       <= '0;
      word_idx         <= '0;
      byte_cnt         <= '0;
      word_reg         <= '0;
      csum             <= '0;
    end else begin
      mem_write_enable <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state     <= HDR_HI;
            in_ready  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
            csum      <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            word_reg  <= '0;
          end
        end
        HDR_HI: begin
          if (in_valid) begin
            hdr_hi <= in_data;
            csum   <= csum ^ in_data;
            state  <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (in_valid) begin
            word_count <= next_count;
            csum       <= csum ^ in_data;
            if ({16'd0, next_count} > MAX_WORDS) begin
              state    <= ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else if (next_count == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (in_valid) begin
            word_reg <= next_word;
            csum     <= csum ^ in_data;
            if (byte_cnt == BCW'(BPW - 1)) begin
              byte_cnt         <= '0;
              state            <= WRITE;
              in_ready         <= 1'b0;
              mem_write_enable <= 1'b1;
              mem_address      <= RAM_ADDR_BITS'(PROG_START_ADDR) + word_idx;
              mem_input_data   <= next_word;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          in_ready <= 1'b1;
          if (16'(word_idx) == word_count - 16'd1) begin
            state <= CSUM;
          end else begin
            word_idx <= word_idx + 1'b1;
            state    <= DATA;
          end
        end
        CSUM: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: scoreboard of expected memory writes plus
// per-scenario checks of handshake bubbles and final status outputs.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_write_enable;
  logic [8:0] mem_address;
  logic [31:0] mem_input_data;
  logic       cpu_reset;
  logic       done;
  logic       error;

  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  prog_loader dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_input_data   (mem_input_data),
    .cpu_reset        (cpu_reset),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (reset === 1'b0 && mem_write_enable === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_write: got addr=%0h data=%08h, required no write", mem_address, mem_input_data);
      end else begin
        e = exp_q.pop_front();
        if ({mem_address, mem_input_data} !== {e.addr, e.data}) begin
          bad++;
          $display("[TB] FAIL write_value: got addr=%0h data=%08h, required addr=%0h data=%08h",
                   mem_address, mem_input_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int stalls);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("[TB] FAIL send_timeout: byte %02h not accepted after %0d cycles, required acceptance", b, n);
    end
    @(posedge clk);
    #1;
    stalls = n;
  endtask

  task automatic end_stream();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_status(input string name, input logic exp_done, input logic exp_error,
                              input logic exp_cpu_reset);
    total++;
    if (done !== exp_done) begin
      bad++;
      $display("[TB] FAIL %s_done: got %b, required %b", name, done, exp_done);
    end
    total++;
    if (error !== exp_error) begin
      bad++;
      $display("[TB] FAIL %s_error: got %b, required %b", name, error, exp_error);
    end
    total++;
    if (cpu_reset !== exp_cpu_reset) begin
      bad++;
      $display("[TB] FAIL %s_cpu_reset: got %b, required %b", name, cpu_reset, exp_cpu_reset);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_in_ready: got %b, required 0", name, in_ready);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_writes_missing: got %0d outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, mem_write_enable, mem_address, mem_input_data} !== 43'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got rdy=%b we=%b addr=%0h data=%08h, required all zero",
               in_ready, mem_write_enable, mem_address, mem_input_data);
    end
    check_status("reset", 1'b0, 1'b0, 1'b1);
  endtask

  // Two-word load; checksum byte selects success or failure.
  task automatic run_two_words(input string name, input logic [7:0] csum_byte, input logic good);
    logic [7:0] bytes [11];
    int exp_stall [11];
    int st;
    bytes = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, csum_byte};
    exp_stall = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    exp_q.push_back('{addr: 9'd0, data: 32'h11223344});
    exp_q.push_back('{addr: 9'd1, data: 32'hAABBCCDD});
    pulse_start();
    for (int i = 0; i < 11; i++) begin
      send_byte(bytes[i], st);
      total++;
      if (st !== exp_stall[i]) begin
        bad++;
        $display("[TB] FAIL %s_stall_byte%0d: got %0d, required %0d", name, i, st, exp_stall[i]);
      end
    end
    end_stream();
    check_status(name, good, !good, !good);
  endtask

  task automatic test_back_to_back();
    run_two_words("good_load", 8'h46, 1'b1);
  endtask

  task automatic test_bad_checksum();
    run_two_words("bad_csum", 8'h47, 1'b0);
    run_two_words("reload", 8'h46, 1'b1);
  endtask

  task automatic test_empty_image();
    int st;
    pulse_start();
    send_byte(8'h00, st);
    send_byte(8'h00, st);
    send_byte(8'h00, st);
    end_stream();
    check_status("empty", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_oversize();
    int st;
    pulse_start();
    send_byte(8'h02, st);
    send_byte(8'h01, st);
    end_stream();
    check_status("oversize", 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || error !== 1'b1) begin
      bad++;
      $display("[TB] FAIL oversize_sticky: got rdy=%b err=%b, required rdy=0 err=1", in_ready, error);
    end
  endtask

  task automatic test_start_ignored();
    int st;
    exp_q.push_back('{addr: 9'd0, data: 32'h11223344});
    pulse_start();
    send_byte(8'h00, st);
    send_byte(8'h01, st);
    send_byte(8'h11, st);
    send_byte(8'h22, st);
    pulse_start();
    send_byte(8'h33, st);
    send_byte(8'h44, st);
    send_byte(8'h45, st);
    end_stream();
    check_status("start_ignored", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    int st;
    pulse_start();
    send_byte(8'h00, st);
    send_byte(8'h01, st);
    send_byte(8'h11, st);
    end_stream();
    repeat (2) @(negedge clk);
    send_byte(8'h22, st);
    end_stream();
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h33;
    reset    = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    in_data  = 8'h44;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    check_status("reset_mid", 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bad_checksum();
    test_empty_image();
    test_oversize();
    test_start_ignored();
    test_reset_mid_load();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
